// File: rtl/bcd_scan_display.sv
// bcd_scan_display: snapshots a BCD counter chain once per scan frame and
// drives a time-multiplexed common-anode 7-segment display (active-low pins).
// Optional feature macro: LEADING_ZERO_BLANK_EN (suppresses leading zeros).
module bcd_scan_display #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 1000
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic                    hold,
  input  logic                    blank,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame
);

  localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [PW-1:0]           presc_q;
  logic [IW-1:0]           idx_q;
  logic [4*NUM_DIGITS-1:0] snap_q;
  logic [NUM_DIGITS-1:0]   snap_dp_q;

  logic                    presc_last_c;
  logic                    idx_last_c;
  logic                    wrap_c;
  logic [3:0]              cur_c;
  logic                    cur_dp_c;
  logic                    cur_lz_c;
  logic [6:0]              dec_c;
  logic [6:0]              seg_c;
  logic [NUM_DIGITS-1:0]   an_c;

  assign presc_last_c = (presc_q == PW'(REFRESH_DIV - 1));
  assign idx_last_c   = (idx_q == IW'(NUM_DIGITS - 1));
  assign wrap_c       = presc_last_c && idx_last_c;

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] lz_c;
  logic                  zacc_c;

  // lz_c[k]: snapshot digit k and every digit above it are zero
  always_comb begin
    lz_c   = '0;
    zacc_c = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zacc_c  = zacc_c && (snap_q[4*k +: 4] == 4'd0);
      lz_c[k] = zacc_c;
    end
  end
`endif

  // Select the snapshot digit, its dp bit and blanking flag for the current slot
  always_comb begin
    cur_c    = 4'd0;
    cur_dp_c = 1'b0;
    cur_lz_c = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        cur_c    = snap_q[4*k +: 4];
        cur_dp_c = snap_dp_q[k];
`ifdef LEADING_ZERO_BLANK_EN
        cur_lz_c = (k != 0) && lz_c[k];
`endif
      end
    end
  end

  // BCD to active-low segments {g,f,e,d,c,b,a}; invalid codes show a dash
  always_comb begin
    dec_c = 7'h3F;
    case (cur_c)
      4'd0:    dec_c = 7'h40;
      4'd1:    dec_c = 7'h79;
      4'd2:    dec_c = 7'h24;
      4'd3:    dec_c = 7'h30;
      4'd4:    dec_c = 7'h19;
      4'd5:    dec_c = 7'h12;
      4'd6:    dec_c = 7'h02;
      4'd7:    dec_c = 7'h78;
      4'd8:    dec_c = 7'h00;
      4'd9:    dec_c = 7'h10;
      default: dec_c = 7'h3F;
    endcase
  end

  // Next segment/anode values; a blanked leading zero keeps its anode only for a lit dp
  always_comb begin
    seg_c = dec_c;
    an_c  = ~(NUM_DIGITS'(1) << idx_q);
    if (cur_lz_c) begin
      seg_c = 7'h7F;
      if (!cur_dp_c) an_c = '1;
    end
    if (blank) an_c = '1;
  end

  // Prescaler, scan index and frame snapshot
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      presc_q   <= '0;
      idx_q     <= '0;
      snap_q    <= '0;
      snap_dp_q <= '0;
      frame     <= 1'b0;
    end else begin
      presc_q <= presc_last_c ? '0 : presc_q + PW'(1);
      if (presc_last_c) idx_q <= idx_last_c ? '0 : idx_q + IW'(1);
      if (wrap_c && !hold) begin
        snap_q    <= digits;
        snap_dp_q <= dp_mask;
      end
      frame <= wrap_c && !hold;
    end
  end

  // Registered display pins, one cycle behind the scan index
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      seg <= 7'h7F;
      dp  <= 1'b1;
      an  <= '1;
    end else begin
      seg <= seg_c;
      dp  <= ~cur_dp_c;
      an  <= an_c;
    end
  end

endmodule

// File: tb/tb_bcd_scan_display.sv
// Self-checking bench for bcd_scan_display (NUM_DIGITS=4, REFRESH_DIV=4).
// Honors LEADING_ZERO_BLANK_EN when defined.
module tb_bcd_scan_display;

  localparam int N  = 4;
  localparam int RD = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic [4*N-1:0] digits;
  logic [N-1:0]  dp_mask;
  logic          hold;
  logic          blank;
  logic [6:0]    seg;
  logic          dp;
  logic [N-1:0]  an;
  logic          frame;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [6:0] SEG_TAB [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

  bcd_scan_display #(.NUM_DIGITS(N), .REFRESH_DIV(RD)) dut (
    .clk(clk), .rstn(rstn), .digits(digits), .dp_mask(dp_mask),
    .hold(hold), .blank(blank), .seg(seg), .dp(dp), .an(an), .frame(frame)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: t edges since reset; slot = (t/RD) mod N; snapshot every N*RD edges
  int         t;
  logic [3:0] ms [N];
  logic [N-1:0] mdp;
  logic [6:0] e_seg;
  logic       e_dp;
  logic [N-1:0] e_an;
  logic       e_frame;

  always @(posedge clk or negedge rstn) begin
    int k;
    int nt;
    logic [6:0] s;
    logic [N-1:0] a;
    logic allz;
    if (!rstn) begin
      t <= 0;
      for (int j = 0; j < N; j++) ms[j] <= 4'd0;
      mdp <= '0;
      e_seg <= 7'h7F; e_dp <= 1'b1; e_an <= '1; e_frame <= 1'b0;
    end else begin
      k = (t / RD) % N;
      s = SEG_TAB[ms[k]];
      a = '1;
      a[k] = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      allz = 1'b1;
      for (int j = k; j < N; j++) if (ms[j] != 4'd0) allz = 1'b0;
      if (k > 0 && allz) begin
        s = 7'h7F;
        if (!mdp[k]) a = '1;
      end
`else
      allz = 1'b0;
`endif
      if (blank) a = '1;
      e_seg <= s;
      e_an  <= a;
      e_dp  <= ~mdp[k];
      nt = t + 1;
      t <= nt;
      if ((nt % (RD * N)) == 0 && !hold) begin
        e_frame <= 1'b1;
        for (int j = 0; j < N; j++) ms[j] <= digits[4*j +: 4];
        mdp <= dp_mask;
      end else begin
        e_frame <= 1'b0;
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (rstn) begin
      chk("seg", 32'(seg), 32'(e_seg));
      chk("an", 32'(an), 32'(e_an));
      chk("dp", 32'(dp), 32'(e_dp));
      chk("frame", 32'(frame), 32'(e_frame));
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_dark(input string tag);
    chk({tag, "_seg"}, 32'(seg), 32'h7F);
    chk({tag, "_dp"}, 32'(dp), 32'h1);
    chk({tag, "_an"}, 32'(an), 32'hF);
    chk({tag, "_frame"}, 32'(frame), 32'h0);
  endtask

  function automatic logic [15:0] rnd_digits();
    logic [15:0] d;
    for (int j = 0; j < N; j++)
      d[4*j +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
    return d;
  endfunction

  initial begin
    rstn = 1'b0; digits = 16'h1234; dp_mask = '0; hold = 1'b0; blank = 1'b0;
    run(3);
    chk_dark("reset");
    rstn = 1'b1;
    run(1);                            // t=1: pre-capture snapshot is zero
    chk("t1_an", 32'(an), 32'hE);
    chk("t1_seg", 32'(seg), 32'h40);
    run(15);                           // t=16: first wrap
    chk("t16_frame", 32'(frame), 32'h1);
    run(1);
    chk("t17_seg", 32'(seg), 32'h19);
    chk("t17_an", 32'(an), 32'hE);
    run(2);
    digits = 16'h5678;                 // mid-frame change
    run(14);                           // t=33
    chk("t33_seg", 32'(seg), 32'h00);
    hold = 1'b1; digits = 16'h9999;
    run(15);                           // t=48: held wrap
    chk("t48_frame", 32'(frame), 32'h0);
    run(1);
    chk("t49_seg", 32'(seg), 32'h00);
    hold = 1'b0;
    run(16);                           // t=65
    chk("t65_seg", 32'(seg), 32'h10);
    digits = 16'h00A7;
    run(16);                           // t=81
    chk("t81_seg", 32'(seg), 32'h78);
    run(4);                            // t=85: digit 1 = A
    chk("t85_seg", 32'(seg), 32'h3F);
    run(11);
    dp_mask = 4'b0100;
    for (int i = 0; i < 48; i++) begin
      blank = ($urandom_range(0, 3) == 0);
      run(1);
    end
    blank = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) digits = rnd_digits();
      if ($urandom_range(0, 7) == 0) dp_mask = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) hold = ~hold;
      blank = ($urandom_range(0, 9) == 0);
      run(1);
    end
    hold = 1'b0; blank = 1'b0;
    @(posedge clk);
    #2 rstn = 1'b0;                    // async reset between edges
    #1 chk_dark("async");
    run(2);
    rstn = 1'b1;
    run(1);
    chk("restart_an", 32'(an), 32'hE);
    for (int i = 0; i < 100; i++) begin
      if ($urandom_range(0, 4) == 0) digits = rnd_digits();
      if ($urandom_range(0, 4) == 0) dp_mask = 4'($urandom_range(0, 15));
      run(1);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
